readout_timing_gen: RTL and testbench

- Row-sequenced readout timing generator for the image-sensor column and PGA/ADC chain.
- A trigger starts a frame of NUM_ROW rows. For each row it drives ROWADD and a fixed set of column, pixel and PGA control pulses.
- All pulse positions and widths come from runtime inputs T1..T14, counted in CLK cycles.
- It also produces per-column ADC data-valid strobes.

---
 rtl/readout_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_readout_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_timing_gen.sv
// rtl/readout_timing_gen.sv - row-sequenced readout timing generator for the column and PGA/ADC chain
// Optional ADC data-valid strobes are built only when ADC_VALID_EN is defined.
module readout_timing_gen #(
    parameter int TW = 16,
    parameter int RW = 10,
    parameter int CW = 8,
    parameter int LW = 6
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          trigger,
    output logic          re_busy,
    input  logic          PGA_en,
    output logic [RW-1:0] ROWADD,
    output logic          COL_L_EN,
    output logic          COL_PRECH,
    output logic          PIXRES,
    output logic          MUX_START,
    output logic          CP_MUX_IN,
    output logic          READ_R,
    output logic          READ_S,
    output logic          PGA_RES,
    output logic          PH1,
    output logic          SAMP_S,
    output logic          SAMP_R,
    input  logic [TW-1:0] T1,
    input  logic [TW-1:0] T2,
    input  logic [TW-1:0] T3,
    input  logic [TW-1:0] T4,
    input  logic [TW-1:0] T5,
    input  logic [TW-1:0] T6,
    input  logic [TW-1:0] T7,
    input  logic [TW-1:0] T8,
    input  logic [TW-1:0] T9,
    input  logic [TW-1:0] T10,
    input  logic [TW-1:0] T11,
    input  logic [TW-1:0] T12,
    input  logic [TW-1:0] T13,
    input  logic [TW-1:0] T14,
    input  logic [CW-1:0] NL,
    input  logic [CW-1:0] NR,
    input  logic [RW-1:0] NUM_ROW,
    input  logic          adc_clk,
    input  logic          adc1_out_clk,
    input  logic          adc2_out_clk,
    input  logic [LW-1:0] Tlat1,
    input  logic [LW-1:0] Tlat2,
    output logic          adc1_dat_valid,
    output logic          adc2_dat_valid
);

    localparam int XW  = TW + CW + 2;
    localparam int TW1 = TW + 1;
    localparam int RW1 = RW + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] t, t_nxt;
    logic [RW-1:0] row, row_nxt;
    logic          row_end, last_row;

    assign row_end  = (TW1'(t) + TW1'(1)) >= TW1'(T1);
    assign last_row = (RW1'(row) + RW1'(1)) >= RW1'(NUM_ROW);

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        row_nxt   = row;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = RUN;
                    t_nxt     = '0;
                    row_nxt   = '0;
                end
            end
            RUN: begin
                if (row_end || NUM_ROW == '0) begin
                    if (last_row) begin
                        state_nxt = IDLE;
                    end else begin
                        row_nxt = row + RW'(1);
                        t_nxt   = '0;
                    end
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is computed from the next t so that it is registered yet aligned with t.
    logic          run_pulse;
    logic [XW-1:0] tx;

    assign run_pulse = (state_nxt == RUN) && (NUM_ROW != '0) && (T1 != '0);
    assign tx        = XW'(t_nxt);

    function automatic logic in_win(input logic [XW-1:0] tv, input logic [XW-1:0] a,
                                    input logic [XW-1:0] w);
        return (tv >= a) && (tv < a + w);
    endfunction

    // Burst trackers: index 0 is the left burst, index 1 the right burst.
    logic [1:0][XW-1:0] base;
    logic [1:0][CW-1:0] num;
    logic [1:0][XW-1:0] rr_end;
    logic [1:0]         burst_ok;
    logic [1:0]         act, act_n;
    logic [1:0][TW-1:0] ph, ph_n;
    logic [1:0][CW-1:0] k, k_n;
    logic [1:0]         cp_b, rs_b, rr_b;
    logic [TW-1:0]      half6;
    logic               long_rr;

    assign base[0] = XW'(T5);
    assign base[1] = XW'(T9) + XW'(T10);
    assign num[0]  = NL;
    assign num[1]  = NR;
    assign half6   = T6 >> 1;
    assign long_rr = T7 > T6;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            burst_ok[i] = (num[i] != '0) && (T6 != '0);
            rr_end[i]   = base[i] + XW'(num[i] - CW'(1)) * XW'(T6) + XW'(T7);
            act_n[i]    = act[i];
            ph_n[i]     = ph[i];
            k_n[i]      = k[i];
            if (run_pulse && tx == base[i] && burst_ok[i]) begin
                act_n[i] = 1'b1;
                ph_n[i]  = '0;
                k_n[i]   = '0;
            end else if (!run_pulse || t_nxt == '0) begin
                act_n[i] = 1'b0;
            end else if (act[i]) begin
                if (ph[i] == T6 - TW'(1)) begin
                    ph_n[i] = '0;
                    if (k[i] == num[i] - CW'(1)) begin
                        act_n[i] = 1'b0;
                    end else begin
                        k_n[i] = k[i] + CW'(1);
                    end
                end else begin
                    ph_n[i] = ph[i] + TW'(1);
                end
            end
            cp_b[i] = act_n[i] && (ph_n[i] < half6);
            rs_b[i] = act_n[i] && (ph_n[i] >= T8);
            // A read window longer than the period merges into one span up to the last start plus T7.
            rr_b[i] = (act_n[i] && (ph_n[i] < T7)) ||
                      (run_pulse && long_rr && burst_ok[i] && tx >= base[i] && tx < rr_end[i]);
        end
    end

    logic [TW-1:0] ph1_cnt, ph1_cnt_n;

    always_comb begin
        ph1_cnt_n = ph1_cnt + TW'(1);
        if (!run_pulse || t_nxt == '0 || ph1_cnt == T12 - TW'(1)) begin
            ph1_cnt_n = '0;
        end
    end

    logic col_l_n, col_prech_n, pixres_n, mux_start_n, cp_mux_n, read_r_n, read_s_n;
    logic pga_res_n, ph1_n, samp_s_n, samp_r_n;

    always_comb begin
        col_l_n     = run_pulse && in_win(tx, '0, XW'(T2));
        col_prech_n = run_pulse && in_win(tx, '0, XW'(T3));
        pixres_n    = run_pulse && in_win(tx, XW'(T9), XW'(T10));
        mux_start_n = run_pulse && (in_win(tx, base[0], XW'(T4)) || in_win(tx, base[1], XW'(T4)));
        cp_mux_n    = |cp_b;
        read_r_n    = |rr_b;
        read_s_n    = |rs_b;
        pga_res_n   = run_pulse && PGA_en && in_win(tx, XW'(T3), XW'(T11));
        ph1_n       = run_pulse && PGA_en && (ph1_cnt_n < (T12 >> 1));
        samp_s_n    = run_pulse && in_win(tx, XW'(T3) + XW'(T13), XW'(T14));
        samp_r_n    = run_pulse && in_win(tx, base[1] + XW'(T13), XW'(T14));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            row       <= '0;
            act       <= '0;
            ph        <= '0;
            k         <= '0;
            ph1_cnt   <= '0;
            COL_L_EN  <= 1'b0;
            COL_PRECH <= 1'b0;
            PIXRES    <= 1'b0;
            MUX_START <= 1'b0;
            CP_MUX_IN <= 1'b0;
            READ_R    <= 1'b0;
            READ_S    <= 1'b0;
            PGA_RES   <= 1'b0;
            PH1       <= 1'b0;
            SAMP_S    <= 1'b0;
            SAMP_R    <= 1'b0;
        end else begin
            state     <= state_nxt;
            t         <= t_nxt;
            row       <= row_nxt;
            act       <= act_n;
            ph        <= ph_n;
            k         <= k_n;
            ph1_cnt   <= ph1_cnt_n;
            COL_L_EN  <= col_l_n;
            COL_PRECH <= col_prech_n;
            PIXRES    <= pixres_n;
            MUX_START <= mux_start_n;
            CP_MUX_IN <= cp_mux_n;
            READ_R    <= read_r_n;
            READ_S    <= read_s_n;
            PGA_RES   <= pga_res_n;
            PH1       <= ph1_n;
            SAMP_S    <= samp_s_n;
            SAMP_R    <= samp_r_n;
        end
    end

    assign re_busy = (state == RUN);
    assign ROWADD  = row;

    logic unused_adc_clk;
    assign unused_adc_clk = adc_clk;

`ifdef ADC_VALID_EN
    logic cp_flag;

    always_ff @(posedge CLK) begin
        if (rst) begin
            cp_flag <= 1'b0;
        end else if (cp_mux_n && !CP_MUX_IN) begin
            cp_flag <= ~cp_flag;
        end
    end

    logic [1:0]    oclk;
    logic [1:0]    adc_v;
    logic [LW-1:0] tlat [2];

    assign oclk    = {adc2_out_clk, adc1_out_clk};
    assign tlat[0] = Tlat1;
    assign tlat[1] = Tlat2;

    for (genvar g = 0; g < 2; g++) begin : g_adc
        logic [1:0]  rst_sync;
        logic [2:0]  flag_sync;
        logic [63:0] sr;
        logic        strobe;
        logic        v;

        assign strobe = flag_sync[2] ^ flag_sync[1];

        always_ff @(posedge oclk[g]) begin
            rst_sync <= {rst_sync[0], rst};
            if (rst_sync[1]) begin
                flag_sync <= '0;
                sr        <= '0;
                v         <= 1'b0;
            end else begin
                flag_sync <= {flag_sync[1:0], cp_flag};
                sr        <= {sr[62:0], strobe};
                v         <= (tlat[g] == '0) ? strobe : sr[tlat[g] - LW'(1)];
            end
        end

        assign adc_v[g] = v;
    end

    assign adc1_dat_valid = adc_v[0];
    assign adc2_dat_valid = adc_v[1];
`else
    logic unused_adc_out;
    assign unused_adc_out = ^{adc1_out_clk, adc2_out_clk, Tlat1, Tlat2};
    assign adc1_dat_valid = 1'b0;
    assign adc2_dat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_readout_timing_gen.sv
// tb/tb_readout_timing_gen.sv - directed self-checking bench for readout_timing_gen
module tb_readout_timing_gen;

    localparam int TW = 16;
    localparam int RW = 10;
    localparam int CW = 8;
    localparam int LW = 6;
    localparam int CLK_NS = 10;
    localparam int ROW_CAP = 1724;

    localparam int B_COL_L = 0, B_PRECH = 1, B_PIXRES = 2, B_MUXST = 3, B_CP = 4, B_RR = 5;
    localparam int B_RS = 6, B_PGARES = 7, B_PH1 = 8, B_SAMPS = 9, B_SAMPR = 10;

    logic          CLK = 1'b0;
    logic          rst, trigger, PGA_en, re_busy;
    logic [RW-1:0] ROWADD, NUM_ROW;
    logic          COL_L_EN, COL_PRECH, PIXRES, MUX_START, CP_MUX_IN, READ_R, READ_S;
    logic          PGA_RES, PH1, SAMP_S, SAMP_R;
    logic [TW-1:0] T1, T2, T3, T4, T5, T6, T7, T8, T9, T10, T11, T12, T13, T14;
    logic [CW-1:0] NL, NR;
    logic          adc_clk = 1'b0, adc1_out_clk = 1'b0, adc2_out_clk = 1'b0;
    logic [LW-1:0] Tlat1, Tlat2;
    logic          adc1_dat_valid, adc2_dat_valid;

    always #5 CLK = ~CLK;
    always #4 adc_clk = ~adc_clk;
    always #6 adc1_out_clk = ~adc1_out_clk;
    always #7 adc2_out_clk = ~adc2_out_clk;

    readout_timing_gen #(.TW(TW), .RW(RW), .CW(CW), .LW(LW)) dut (
        .CLK(CLK), .rst(rst), .trigger(trigger), .re_busy(re_busy), .PGA_en(PGA_en),
        .ROWADD(ROWADD), .COL_L_EN(COL_L_EN), .COL_PRECH(COL_PRECH), .PIXRES(PIXRES),
        .MUX_START(MUX_START), .CP_MUX_IN(CP_MUX_IN), .READ_R(READ_R), .READ_S(READ_S),
        .PGA_RES(PGA_RES), .PH1(PH1), .SAMP_S(SAMP_S), .SAMP_R(SAMP_R),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7), .T8(T8), .T9(T9),
        .T10(T10), .T11(T11), .T12(T12), .T13(T13), .T14(T14), .NL(NL), .NR(NR),
        .NUM_ROW(NUM_ROW), .adc_clk(adc_clk), .adc1_out_clk(adc1_out_clk),
        .adc2_out_clk(adc2_out_clk), .Tlat1(Tlat1), .Tlat2(Tlat2),
        .adc1_dat_valid(adc1_dat_valid), .adc2_dat_valid(adc2_dat_valid)
    );

    logic [10:0] o_vec;
    assign o_vec = {SAMP_R, SAMP_S, PH1, PGA_RES, READ_S, READ_R, CP_MUX_IN, MUX_START,
                    PIXRES, COL_PRECH, COL_L_EN};

    int          n_tests = 0;
    int          n_fail = 0;
    int          busy_cyc;
    int          ones [11];
    int          adc_ones;
    int          chg_cyc [$];
    logic [10:0] cap [0:ROW_CAP-1];

    function automatic int rise_from(input int b, input int start);
        for (int i = start; i < ROW_CAP; i++) begin
            if (cap[i][b] && (i == 0 || !cap[i-1][b])) return i;
        end
        return -1;
    endfunction

    function automatic int width_at(input int b, input int s);
        int w = 0;
        if (s < 0) return -1;
        for (int i = s; i < ROW_CAP && cap[i][b]; i++) w++;
        return w;
    endfunction

    function automatic int n_rises(input int b);
        int n = 0;
        for (int i = 0; i < ROW_CAP; i++) begin
            if (cap[i][b] && (i == 0 || !cap[i-1][b])) n++;
        end
        return n;
    endfunction

    task automatic set_cfg(input int nrow, input logic pga);
        T1 = 1724; T2 = 862; T3 = 2; T4 = 3; T5 = 2; T6 = 20; T7 = 9; T8 = 11;
        T9 = 431; T10 = 2; T11 = 2; T12 = 10; T13 = 2; T14 = 200;
        NL = 8; NR = 8; NUM_ROW = RW'(nrow); PGA_en = pga; Tlat1 = 25; Tlat2 = 25;
    endtask

    task automatic run_frame(input int inj_a, input int inj_b);
        logic [RW-1:0] prev_row;
        busy_cyc = 0;
        adc_ones = 0;
        chg_cyc.delete();
        prev_row = '0;
        for (int b = 0; b < 11; b++) ones[b] = 0;
        for (int i = 0; i < ROW_CAP; i++) cap[i] = '0;
        @(negedge CLK);
        trigger = 1'b1;
        @(negedge CLK);
        trigger = 1'b0;
        while (re_busy && busy_cyc < 40000) begin
            if (busy_cyc < ROW_CAP) cap[busy_cyc] = o_vec;
            for (int b = 0; b < 11; b++) ones[b] += int'(o_vec[b]);
            adc_ones += int'(adc1_dat_valid) + int'(adc2_dat_valid);
            if (busy_cyc == 0) prev_row = ROWADD;
            if (ROWADD != prev_row) begin
                chg_cyc.push_back(busy_cyc);
                prev_row = ROWADD;
            end
            trigger = (busy_cyc == inj_a || busy_cyc == inj_b);
            @(negedge CLK);
            busy_cyc++;
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trigger = 1'b1;
        set_cfg(20, 1'b1);
        repeat (20) @(negedge CLK);
        n_tests++;
        if (o_vec !== 11'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", o_vec); end
        n_tests++;
        if (re_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", re_busy); end
        n_tests++;
        if (ROWADD !== '0) begin n_fail++; $display("FAIL reset_rowadd: got %0d want 0", ROWADD); end
        n_tests++;
        if ({adc1_dat_valid, adc2_dat_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_adc_valid: got %b want 00", {adc1_dat_valid, adc2_dat_valid});
        end
        rst = 1'b0;
        trigger = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (re_busy !== 1'b0) begin n_fail++; $display("FAIL reset_trigger_ignored: busy %b want 0", re_busy); end
    endtask

    task automatic test_frame();
        int bad;
        set_cfg(20, 1'b1);
        run_frame(100, 34479);
        n_tests++;
        if (busy_cyc != 34480) begin n_fail++; $display("FAIL frame_busy_cycles: got %0d want 34480", busy_cyc); end
        n_tests++;
        if (chg_cyc.size() != 19) begin n_fail++; $display("FAIL frame_row_changes: got %0d want 19", chg_cyc.size()); end
        bad = 0;
        for (int i = 1; i < chg_cyc.size(); i++) begin
            if ((chg_cyc[i] - chg_cyc[i-1]) * CLK_NS != 17240) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL frame_row_spacing: %0d gaps not 17240 ns", bad); end
        n_tests++;
        if (ROWADD !== 10'd19) begin n_fail++; $display("FAIL frame_rowadd_hold: got %0d want 19", ROWADD); end
        repeat (5) @(negedge CLK);
        n_tests++;
        if (re_busy !== 1'b0) begin n_fail++; $display("FAIL frame_trigger_in_busy: busy %b want 0", re_busy); end
`ifndef ADC_VALID_EN
        n_tests++;
        if (adc_ones != 0) begin n_fail++; $display("FAIL adc_valid_tied: got %0d pulses want 0", adc_ones); end
`endif
    endtask

    task automatic test_pulse_widths();
        int w;
        w = width_at(B_COL_L, rise_from(B_COL_L, 0));
        n_tests++;
        if (w * CLK_NS != 8620) begin n_fail++; $display("FAIL width_col_l_en: got %0d ns want 8620", w * CLK_NS); end
        w = width_at(B_PRECH, rise_from(B_PRECH, 0));
        n_tests++;
        if (w * CLK_NS != 20) begin n_fail++; $display("FAIL width_col_prech: got %0d ns want 20", w * CLK_NS); end
        w = width_at(B_MUXST, rise_from(B_MUXST, 0));
        n_tests++;
        if (w * CLK_NS != 30) begin n_fail++; $display("FAIL width_mux_start: got %0d ns want 30", w * CLK_NS); end
        w = width_at(B_RR, rise_from(B_RR, 0));
        n_tests++;
        if (w * CLK_NS != 90) begin n_fail++; $display("FAIL width_read_r: got %0d ns want 90", w * CLK_NS); end
        w = width_at(B_PIXRES, rise_from(B_PIXRES, 0));
        n_tests++;
        if (w * CLK_NS != 20) begin n_fail++; $display("FAIL width_pixres: got %0d ns want 20", w * CLK_NS); end
        w = width_at(B_PGARES, rise_from(B_PGARES, 0));
        n_tests++;
        if (w * CLK_NS != 20) begin n_fail++; $display("FAIL width_pga_res: got %0d ns want 20", w * CLK_NS); end
        w = width_at(B_SAMPS, rise_from(B_SAMPS, 0));
        n_tests++;
        if (w * CLK_NS != 2000) begin n_fail++; $display("FAIL width_samp_s: got %0d ns want 2000", w * CLK_NS); end
        w = width_at(B_RS, rise_from(B_RS, 0));
        n_tests++;
        if (w != 9) begin n_fail++; $display("FAIL width_read_s: got %0d cycles want 9", w); end
        w = n_rises(B_CP);
        n_tests++;
        if (w != 16) begin n_fail++; $display("FAIL cp_pulses_per_row: got %0d want 16", w); end
        w = n_rises(B_MUXST);
        n_tests++;
        if (w != 2) begin n_fail++; $display("FAIL mux_start_per_row: got %0d want 2", w); end
    endtask

    task automatic test_offsets();
        int r_prech, r_cp, r_cp2, r_rs, r_pix, r_pga, r_samps, r_ph0, r_ph1;
        r_prech = rise_from(B_PRECH, 0);
        r_cp    = rise_from(B_CP, 0);
        r_cp2   = rise_from(B_CP, r_cp + 1);
        r_rs    = rise_from(B_RS, 0);
        r_pix   = rise_from(B_PIXRES, 0);
        r_pga   = rise_from(B_PGARES, 0);
        r_samps = rise_from(B_SAMPS, 0);
        r_ph0   = rise_from(B_PH1, 0);
        r_ph1   = rise_from(B_PH1, r_ph0 + 1);
        n_tests++;
        if (r_prech != 0) begin n_fail++; $display("FAIL prech_start: got t=%0d want 0", r_prech); end
        n_tests++;
        if ((r_cp - r_prech) * CLK_NS != 20) begin n_fail++; $display("FAIL prech_to_cp: got %0d ns want 20", (r_cp - r_prech) * CLK_NS); end
        n_tests++;
        if ((r_cp2 - r_cp) * CLK_NS != 200) begin n_fail++; $display("FAIL cp_period: got %0d ns want 200", (r_cp2 - r_cp) * CLK_NS); end
        n_tests++;
        if ((r_rs - r_cp) * CLK_NS != 110) begin n_fail++; $display("FAIL cp_to_read_s: got %0d ns want 110", (r_rs - r_cp) * CLK_NS); end
        n_tests++;
        if ((r_pix - r_prech) * CLK_NS != 4310) begin n_fail++; $display("FAIL prech_to_pixres: got %0d ns want 4310", (r_pix - r_prech) * CLK_NS); end
        n_tests++;
        if ((r_samps - r_pga) * CLK_NS != 20) begin n_fail++; $display("FAIL pga_res_to_samp_s: got %0d ns want 20", (r_samps - r_pga) * CLK_NS); end
        n_tests++;
        if ((r_ph1 - r_ph0) * CLK_NS != 100) begin n_fail++; $display("FAIL ph1_period: got %0d ns want 100", (r_ph1 - r_ph0) * CLK_NS); end
        n_tests++;
        if (width_at(B_PH1, r_ph0) != 5) begin n_fail++; $display("FAIL ph1_width: got %0d want 5", width_at(B_PH1, r_ph0)); end
        n_tests++;
        if (rise_from(B_SAMPR, 0) != 435) begin n_fail++; $display("FAIL samp_r_start: got t=%0d want 435", rise_from(B_SAMPR, 0)); end
    endtask

    task automatic test_pga_off();
        set_cfg(2, 1'b0);
        run_frame(-1, -1);
        n_tests++;
        if (busy_cyc != 3448) begin n_fail++; $display("FAIL pga_off_busy: got %0d want 3448", busy_cyc); end
        n_tests++;
        if (ones[B_PGARES] != 0) begin n_fail++; $display("FAIL pga_off_pga_res: got %0d high cycles want 0", ones[B_PGARES]); end
        n_tests++;
        if (ones[B_PH1] != 0) begin n_fail++; $display("FAIL pga_off_ph1: got %0d high cycles want 0", ones[B_PH1]); end
        n_tests++;
        if (rise_from(B_SAMPS, 0) != 4 || width_at(B_SAMPS, 4) != 200) begin
            n_fail++; $display("FAIL pga_off_samp_s: got t=%0d w=%0d want t=4 w=200", rise_from(B_SAMPS, 0), width_at(B_SAMPS, 4));
        end
        n_tests++;
        if (rise_from(B_SAMPR, 0) != 435 || width_at(B_SAMPR, 435) != 200) begin
            n_fail++; $display("FAIL pga_off_samp_r: got t=%0d w=%0d want t=435 w=200", rise_from(B_SAMPR, 0), width_at(B_SAMPR, 435));
        end
    endtask

    task automatic test_truncation();
        set_cfg(2, 1'b1);
        T1 = 5;
        T9 = 1;
        T10 = 0;
        run_frame(-1, -1);
        n_tests++;
        if (busy_cyc != 10) begin n_fail++; $display("FAIL trunc_busy: got %0d want 10", busy_cyc); end
        n_tests++;
        if (ones[B_COL_L] != 10) begin n_fail++; $display("FAIL trunc_col_l_en: got %0d want 10", ones[B_COL_L]); end
        n_tests++;
        if (ones[B_SAMPS] != 2) begin n_fail++; $display("FAIL trunc_samp_s: got %0d want 2", ones[B_SAMPS]); end
        n_tests++;
        if (ones[B_PIXRES] != 0) begin n_fail++; $display("FAIL zero_width_pixres: got %0d want 0", ones[B_PIXRES]); end
    endtask

    task automatic test_num_row_zero();
        int total;
        set_cfg(0, 1'b1);
        run_frame(-1, -1);
        total = 0;
        for (int b = 0; b < 11; b++) total += ones[b];
        n_tests++;
        if (busy_cyc != 1) begin n_fail++; $display("FAIL zero_rows_busy: got %0d want 1", busy_cyc); end
        n_tests++;
        if (total != 0) begin n_fail++; $display("FAIL zero_rows_pulses: got %0d high cycles want 0", total); end
    endtask

    task automatic test_midframe_reset();
        set_cfg(20, 1'b1);
        @(negedge CLK);
        trigger = 1'b1;
        @(negedge CLK);
        trigger = 1'b0;
        repeat (1734) @(negedge CLK);
        n_tests++;
        if (ROWADD !== 10'd1 || COL_L_EN !== 1'b1 || SAMP_S !== 1'b1) begin
            n_fail++; $display("FAIL midframe_precheck: row %0d col_l %b samp_s %b want 1 1 1", ROWADD, COL_L_EN, SAMP_S);
        end
        rst = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (o_vec !== 11'h0) begin n_fail++; $display("FAIL midframe_reset_outputs: got %h want 0", o_vec); end
        n_tests++;
        if (re_busy !== 1'b0 || ROWADD !== '0) begin
            n_fail++; $display("FAIL midframe_reset_state: busy %b row %0d want 0 0", re_busy, ROWADD);
        end
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (re_busy !== 1'b0) begin n_fail++; $display("FAIL midframe_stays_idle: busy %b want 0", re_busy); end
    endtask

    initial begin
        rst = 1'b1;
        trigger = 1'b0;
        set_cfg(20, 1'b1);
        test_reset();
        test_frame();
        test_pulse_widths();
        test_offsets();
        test_pga_off();
        test_truncation();
        test_num_row_zero();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
